// File: rtl/ddr3_app_pkg.sv
// Shared definitions for the DDR3 application-port responder: command
// encodings, default port widths and the burst-index position in the address.
package ddr3_app_pkg;

  typedef enum logic [2:0] {
    CMD_WR = 3'b000,
    CMD_RD = 3'b001
  } ddr3_cmd_e;

  localparam int DDR3_DATA_W = 256;
  localparam int DDR3_ADDR_W = 29;

  // Addresses count 32-bit words; a burst spans 8 of them.
  localparam int BURST_LSB = 3;

endpackage

// File: rtl/ddr3_resp_wdq.sv
// Write-data queue: synchronous FIFO with show-ahead head, full/empty and count.
// The caller never pushes while full and never pops while empty.
module ddr3_resp_wdq #(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] store [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    cnt;

  // Payload storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) store[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign head  = store[rd_ptr];
  assign empty = (cnt == '0);
  assign full  = (cnt == (PTR_W+1)'(DEPTH));
  assign count = cnt;

endmodule

// File: rtl/ddr3_app_responder.sv
// Block-RAM stand-in for the DDR3 IP user port. Accepts write/read commands
// from the FIFO-to-DDR3 adapter, pairs write commands with write data in FIFO
// order, and returns read bursts a fixed RD_LAT cycles after acceptance.
// Optional build macro DDR3_RESP_REFRESH_STALL_EN adds periodic refresh stalls.
module ddr3_app_responder
  import ddr3_app_pkg::*;
#(
  parameter int DATA_W       = DDR3_DATA_W,
  parameter int ADDR_W       = DDR3_ADDR_W,
  parameter int MEM_AW       = 10,
  parameter int CALIB_CYCLES = 64,
  parameter int RD_LAT       = 4,
  parameter int WDQ_DEPTH    = 4
) (
  input  logic              ui_clk,
  input  logic              rst_n,
  input  logic [2:0]        cmd,
  input  logic              cmd_en,
  input  logic [ADDR_W-1:0] addr,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_data_en,
  input  logic              wr_data_end,
  output logic              wr_data_rdy,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_valid,
  output logic              rd_data_end,
  output logic              init_calib_complete,
  output logic              err_illegal
);

  localparam int CAL_W = $clog2(CALIB_CYCLES + 1);
  localparam int QC_W  = $clog2(WDQ_DEPTH) + 1;
  localparam int LAST  = RD_LAT - 2;

  function automatic logic [MEM_AW-1:0] ram_index(input logic [ADDR_W-1:0] a);
    return a[BURST_LSB +: MEM_AW];
  endfunction

  logic [CAL_W-1:0]  cal_cnt;
  logic              calib;
  logic              stall;

  logic              pw_valid;
  logic [MEM_AW-1:0] pw_idx;

  logic [DATA_W-1:0] wdq_head;
  logic              wdq_full;
  logic              wdq_empty;
  logic [QC_W-1:0]   wdq_count;

  logic [DATA_W-1:0] mem [2**MEM_AW];

  logic              vld_p [RD_LAT-1];
  logic [MEM_AW-1:0] idx_p [RD_LAT-1];

  // Calibration: count to CALIB_CYCLES-1, then latch complete for good.
  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      cal_cnt <= '0;
      calib   <= 1'b0;
    end else if (!calib) begin
      if (cal_cnt == CAL_W'(CALIB_CYCLES - 1)) calib <= 1'b1;
      else cal_cnt <= cal_cnt + 1'b1;
    end
  end

`ifdef DDR3_RESP_REFRESH_STALL_EN
  logic [8:0] ref_cnt;

  // Refresh emulation: the last 16 cycles of every 512-cycle window stall.
  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) ref_cnt <= '0;
    else if (calib) ref_cnt <= ref_cnt + 1'b1;
  end

  assign stall = calib && (ref_cnt[8:4] == 5'h1f);
`else
  assign stall = 1'b0;
`endif

  // Handshake decode
  logic              cmd_acc;
  logic              wr_acc;
  logic              wr_cmd;
  logic              rd_cmd;
  logic              ill_cmd;
  logic              commit;
  logic [MEM_AW-1:0] cmd_idx;
  logic [MEM_AW-1:0] commit_idx;
  logic [DATA_W-1:0] commit_data;
  logic              wdq_push;
  logic              wdq_pop;

  assign cmd_ready   = calib && !pw_valid && !stall;
  assign wr_data_rdy = calib && !wdq_full && !stall;

  assign cmd_acc = cmd_en && cmd_ready;
  assign wr_acc  = wr_data_en && wr_data_rdy;
  assign wr_cmd  = cmd_acc && (cmd == CMD_WR);
  assign rd_cmd  = cmd_acc && (cmd == CMD_RD);
  assign ill_cmd = cmd_acc && (cmd != CMD_WR) && (cmd != CMD_RD);
  assign cmd_idx = ram_index(addr);

  // A write address (fresh or parked) commits as soon as any data is at hand;
  // queued data is always older than data arriving this cycle.
  assign commit      = (wr_cmd || pw_valid) && (!wdq_empty || wr_acc);
  assign commit_idx  = pw_valid ? pw_idx : cmd_idx;
  assign commit_data = wdq_empty ? wr_data : wdq_head;
  assign wdq_pop     = commit && !wdq_empty;
  assign wdq_push    = wr_acc && !(commit && wdq_empty);

  ddr3_resp_wdq #(
    .DATA_W (DATA_W),
    .DEPTH  (WDQ_DEPTH)
  ) u_wdq (
    .clk       (ui_clk),
    .rst_n     (rst_n),
    .push      (wdq_push),
    .push_data (wr_data),
    .pop       (wdq_pop),
    .head      (wdq_head),
    .full      (wdq_full),
    .empty     (wdq_empty),
    .count     (wdq_count)
  );

  // Pending-write flag: parks a data-less write, clears when its data lands.
  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) pw_valid <= 1'b0;
    else if (wr_cmd && !commit) pw_valid <= 1'b1;
    else if (pw_valid && commit) pw_valid <= 1'b0;
  end

  // Pending-write address; meaningful only while pw_valid.
  always_ff @(posedge ui_clk) begin
    if (wr_cmd && !commit) pw_idx <= cmd_idx;
  end

  // Backing RAM write port.
  always_ff @(posedge ui_clk) begin
    if (commit) mem[commit_idx] <= commit_data;
  end

  // Stage p0..pN: read valid shift chain, never stalls.
  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < RD_LAT - 1; k++) vld_p[k] <= 1'b0;
      rd_data_valid <= 1'b0;
    end else begin
      vld_p[0] <= rd_cmd;
      for (int k = 1; k < RD_LAT - 1; k++) vld_p[k] <= vld_p[k-1];
      rd_data_valid <= vld_p[LAST];
    end
  end

  // Read index travels beside its valid bit.
  always_ff @(posedge ui_clk) begin
    idx_p[0] <= cmd_idx;
    for (int k = 1; k < RD_LAT - 1; k++) idx_p[k] <= idx_p[k-1];
  end

  // Final stage: RAM read with write-first bypass against a same-cycle commit.
  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else if (vld_p[LAST])
      rd_data <= (commit && (commit_idx == idx_p[LAST])) ? commit_data
                                                          : mem[idx_p[LAST]];
  end

  // Sticky protocol error: bad command code or end marker out of step.
  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) err_illegal <= 1'b0;
    else if (ill_cmd || (wr_data_en != wr_data_end)) err_illegal <= 1'b1;
  end

  assign rd_data_end         = rd_data_valid;
  assign init_calib_complete = calib;

  // Address bits outside the burst index and the queue count are not needed.
  logic unused_bits;
  assign unused_bits = ^{addr, wdq_count};

endmodule

// File: tb/tb_ddr3_app_responder.sv
// Self-checking bench for ddr3_app_responder: a transaction-level model
// (address/data queues, sparse memory, expected-read list) compared every cycle,
// plus directed scenarios with literal expectations.
module tb_ddr3_app_responder;

  localparam int DW  = 256;
  localparam int AW  = 29;
  localparam int MAW = 10;
  localparam int CAL = 64;
  localparam int RDL = 4;
  localparam int WQD = 4;

  logic          ui_clk = 1'b0;
  logic          rst_n  = 1'b1;
  logic [2:0]    cmd = '0;
  logic          cmd_en = 1'b0;
  logic [AW-1:0] addr = '0;
  logic          cmd_ready;
  logic [DW-1:0] wr_data = '0;
  logic          wr_data_en = 1'b0;
  logic          wr_data_end = 1'b0;
  logic          wr_data_rdy;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;
  logic          rd_data_end;
  logic          init_calib_complete;
  logic          err_illegal;

  always #5 ui_clk = ~ui_clk;

  ddr3_app_responder #(
    .DATA_W(DW), .ADDR_W(AW), .MEM_AW(MAW),
    .CALIB_CYCLES(CAL), .RD_LAT(RDL), .WDQ_DEPTH(WQD)
  ) dut (
    .ui_clk(ui_clk), .rst_n(rst_n), .cmd(cmd), .cmd_en(cmd_en), .addr(addr),
    .cmd_ready(cmd_ready), .wr_data(wr_data), .wr_data_en(wr_data_en),
    .wr_data_end(wr_data_end), .wr_data_rdy(wr_data_rdy), .rd_data(rd_data),
    .rd_data_valid(rd_data_valid), .rd_data_end(rd_data_end),
    .init_calib_complete(init_calib_complete), .err_illegal(err_illegal)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct { logic [DW-1:0] d; int due; } rexp_t;
  typedef struct { int c; logic [DW-1:0] d; } cap_t;

  logic [DW-1:0] m_mem [int];
  int            m_wq [$];
  logic [DW-1:0] m_dq [$];
  rexp_t         m_rq [$];
  int            m_cyc = 0;
  bit            m_err = 1'b0;
  cap_t          cap_q [$];

  function automatic int burst_of(input logic [AW-1:0] a);
    return int'((a / 8) % (2 ** MAW));
  endfunction

  function automatic bit m_stall(input int c);
`ifdef DDR3_RESP_REFRESH_STALL_EN
    return (c >= CAL) && (((c - CAL) % 512) >= 496);
`else
    return (c < 0);
`endif
  endfunction

  function automatic bit m_cmd_rdy();
    return (m_cyc >= CAL) && (m_wq.size() == 0) && !m_stall(m_cyc);
  endfunction

  function automatic bit m_dat_rdy();
    return (m_cyc >= CAL) && (m_dq.size() < WQD) && !m_stall(m_cyc);
  endfunction

  always @(posedge ui_clk or negedge rst_n) begin : model
    bit cr;
    bit dr;
    if (!rst_n) begin
      m_wq.delete(); m_dq.delete(); m_rq.delete();
      m_cyc = 0;
      m_err = 1'b0;
    end else begin
      cr = m_cmd_rdy();
      dr = m_dat_rdy();
      if (cmd_en && cr) begin
        if (cmd == 3'b000) m_wq.push_back(burst_of(addr));
        else if (cmd == 3'b001) m_rq.push_back('{m_mem[burst_of(addr)], m_cyc + RDL});
        else m_err = 1'b1;
      end
      if (wr_data_en && dr) m_dq.push_back(wr_data);
      if (wr_data_en != wr_data_end) m_err = 1'b1;
      while (m_wq.size() > 0 && m_dq.size() > 0) m_mem[m_wq.pop_front()] = m_dq.pop_front();
      m_cyc++;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge ui_clk) begin : compare
    bit ev;
    ev = (m_rq.size() > 0) && (m_rq[0].due == m_cyc);
    chk("calib", init_calib_complete, m_cyc >= CAL);
    chk("cmd_ready", cmd_ready, m_cmd_rdy());
    chk("wr_data_rdy", wr_data_rdy, m_dat_rdy());
    chk("err_illegal", err_illegal, m_err);
    chk("rd_valid", rd_data_valid, ev);
    chk("rd_end", rd_data_end, ev);
    if (ev) begin
      chk("rd_data", rd_data, m_rq[0].d);
      void'(m_rq.pop_front());
    end
  end

  always @(negedge ui_clk) if (rd_data_valid) cap_q.push_back('{m_cyc, rd_data});

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge ui_clk);
    #1;
  endtask

  task automatic issue_cmd(input logic [2:0] c, input logic [AW-1:0] a);
    int t;
    cmd = c; addr = a; cmd_en = 1'b1;
    t = 0;
    @(negedge ui_clk);
    while (!cmd_ready && t < 40) begin @(negedge ui_clk); t++; end
    chk("cmd_wait", cmd_ready, 1);
    @(posedge ui_clk); #1;
  endtask

  task automatic cmd_idle();
    cmd_en = 1'b0;
  endtask

  task automatic push_data(input logic [DW-1:0] d);
    int t;
    wr_data = d; wr_data_en = 1'b1; wr_data_end = 1'b1;
    t = 0;
    @(negedge ui_clk);
    while (!wr_data_rdy && t < 40) begin @(negedge ui_clk); t++; end
    chk("data_wait", wr_data_rdy, 1);
    @(posedge ui_clk); #1;
  endtask

  task automatic data_idle();
    wr_data_en = 1'b0; wr_data_end = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat);
    issue_cmd(3'b001, a);
    cmd_idle();
    d = '0;
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge ui_clk);
      if (rd_data_valid) begin d = rd_data; break; end
      lat++;
    end
    @(posedge ui_clk); #1;
  endtask

  task automatic wait_calib(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge ui_clk); #1;
      n++;
      if (init_calib_complete) break;
    end
  endtask

  // ---------------- directed scenarios ----------------
  logic [DW-1:0] pat_a5;
  logic [DW-1:0] dw [4];
  logic [DW-1:0] st_exp [8];
  logic [AW-1:0] st_adr [8];
  logic [DW-1:0] rd;
  int            lat;
  int            n;

  initial begin
    pat_a5 = {32{8'hA5}};
    for (int i = 0; i < 4; i++) dw[i] = {8{32'hD00D_0000 | 32'(i)}};
    st_adr = '{29'h00, 29'h08, 29'h10, 29'h18, 29'h40, 29'h2000, 29'h2008, 29'h00};
    st_exp = '{dw[0], dw[1], dw[2], dw[3], pat_a5, dw[0], dw[1], dw[0]};

    #1 rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;

    // Calibration timing
    wait_calib(n);
    chk("calib_cycles", n, 64);

    // Write command and data together, then read back
    cmd = 3'b000; addr = 29'h40; cmd_en = 1'b1;
    wr_data = pat_a5; wr_data_en = 1'b1; wr_data_end = 1'b1;
    @(negedge ui_clk);
    chk("wr_both_cmd_rdy", cmd_ready, 1);
    chk("wr_both_dat_rdy", wr_data_rdy, 1);
    @(posedge ui_clk); #1;
    cmd_idle(); data_idle();
    do_read(29'h40, rd, lat);
    chk("wr_rd_data", rd, pat_a5);
    chk("rd_latency", lat, 4);

    // Command before data
    issue_cmd(3'b000, 29'h08);
    cmd_idle();
    tick(3);
    chk("pw_blocks_cmd", cmd_ready, 0);
    push_data(256'h1234);
    data_idle();
    chk("cmd_ready_back", cmd_ready, 1);
    do_read(29'h08, rd, lat);
    chk("late_data_read", rd, 256'h1234);

    // Data before commands; fifth word must be refused
    for (int i = 0; i < 4; i++) push_data(dw[i]);
    wr_data = {8{32'hBADD_A7A0}};
    @(negedge ui_clk);
    chk("wdq_full", wr_data_rdy, 0);
    data_idle();
    tick(1);
    for (int i = 0; i < 4; i++) issue_cmd(3'b000, AW'(i * 8));
    cmd_idle();
    chk("wdq_drained", wr_data_rdy, 1);

    // Streaming reads, including aliased addresses
    cap_q.delete();
    for (int i = 0; i < 8; i++) issue_cmd(3'b001, st_adr[i]);
    cmd_idle();
    tick(8);
    chk("stream_count", cap_q.size(), 8);
    for (int i = 0; i < 8 && i < cap_q.size(); i++) chk("stream_data", cap_q[i].d, st_exp[i]);
    if (cap_q.size() == 8) chk("stream_contig", cap_q[7].c - cap_q[0].c, 7);

    // Illegal command: flagged, RAM untouched
    issue_cmd(3'b010, 29'h40);
    cmd_idle();
    tick(1);
    chk("illegal_flag", err_illegal, 1);
    do_read(29'h40, rd, lat);
    chk("illegal_no_write", rd, pat_a5);

    // Reset with a read in flight
    issue_cmd(3'b001, 29'h40);
    cmd_idle();
    rst_n = 1'b0;
    tick(2);
    cap_q.delete();
    rst_n = 1'b1;
    chk("err_cleared", err_illegal, 0);
    wait_calib(n);
    chk("recalib_cycles", n, 64);
    chk("inflight_lost", cap_q.size(), 0);
    do_read(29'h40, rd, lat);
    chk("ram_retained", rd, pat_a5);

    // End marker out of step with data enable
    wr_data_end = 1'b1;
    tick(1);
    wr_data_end = 1'b0;
    chk("end_mismatch", err_illegal, 1);

`ifdef DDR3_RESP_REFRESH_STALL_EN
    n = 0;
    repeat (512) begin
      @(negedge ui_clk);
      if (!cmd_ready) n++;
    end
    chk("refresh_lows", n, 16);
`endif

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
